leaf_out_arbiter: RTL
=====================

Name: leaf_out_arbiter

Overview:
Output-side scheduler for a leaf shell. It shares the single leaf→BFT packet channel between the user kernel's output streams using round-robin arbitration, gated by per-stream credits. For each granted payload it builds a packet from a per-stream route table: valid flag, destination leaf, destination port, write address and payload. It sits between the user-facing vld/ack output ports and the interface's dout toward the BFT. Credits are replenished by freespace-update events decoded upstream.

Parameters:
PACKET_BITS, 49, total packet width (1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS)
PAYLOAD_BITS, 32, user data width
NUM_LEAF_BITS, 5, destination leaf field width
NUM_PORT_BITS, 4, destination port field width
NUM_ADDR_BITS, 7, destination BRAM address width; initial credit = 2^NUM_ADDR_BITS
NUM_OUT_PORTS, 3, number of user output streams (2..8)
FREESPACE_UPDATE_SIZE, 64, credits returned per freespace update

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high
din_user  in  NUM_OUT_PORTS*PAYLOAD_BITS  stream payloads, stream i at [i*32 +: 32]
vld_user  in  NUM_OUT_PORTS  stream i has data
ack_user  out  NUM_OUT_PORTS  one-hot grant; payload i consumed this cycle
cfg_we  in  1  route-table write strobe
cfg_idx  in  3  stream index written
cfg_leaf  in  NUM_LEAF_BITS  destination leaf
cfg_port  in  NUM_PORT_BITS  destination port
fs_vld  in  1  freespace update strobe
fs_idx  in  3  stream receiving +FREESPACE_UPDATE_SIZE credits
dout  out  PACKET_BITS  packet toward BFT
dout_rdy  in  1  BFT side accepts dout this cycle
credit_err  out  1  sticky credit-overflow flag

Behaviour:
- Packet layout: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload. Fields are packed in this order for other parameter values.
- Reset: dout=0, ack_user=0, credit_err=0. All route entries are invalid. Every credit counter = 2^NUM_ADDR_BITS (128). Every addr counter = 0. RR pointer = NUM_OUT_PORTS-1, so stream 0 has first priority.
- Eligibility of stream i: vld_user[i] && route_valid[i] && credit[i]!=0.
- Output slot free: dout[48]==0 || dout_rdy.
- Grant: when the slot is free and at least one stream is eligible, grant the first eligible stream searching from ptr+1 upward with wrap. ack_user is combinational and one-hot in the grant cycle. At most one grant per cycle.
- On a grant to stream i, at the clock edge:
  - dout <= {1, leaf[i], port[i], addr[i], payload_i}
  - addr[i] increments, wrapping 127→0
  - credit[i] decrements
  - ptr <= i
- Latency: vld/ack cycle to dout valid is 1 cycle.
- Slot free but no grant: dout clears to 0.
- Slot not free (dout valid, dout_rdy=0): dout holds unchanged, no ack is issued, and ptr and counters hold.
- Credit arithmetic: counter width NUM_ADDR_BITS+1. Grant and fs_vld to the same stream in one cycle gives a net of −1 + FREESPACE_UPDATE_SIZE.
- Credit overflow: a result above 2^NUM_ADDR_BITS saturates at 128 and sets credit_err. credit_err stays set until reset.
- fs_idx or cfg_idx ≥ NUM_OUT_PORTS: ignored.
- Route writes: cfg_we writes leaf/port and sets route_valid. A grant in the same cycle to the same stream uses the old entry; the new entry applies from the next cycle. addr and credit are unaffected by cfg writes.
- Stream with zero credit: skipped by arbitration. It does not block other streams and does not move ptr.
- Reset asserted mid-operation: immediate return to reset state; any pending dout is dropped.

Test Plan:
1. Single stream: after reset, route stream 0 → leaf 3, port 2; hold vld_user=001 with din 0xA5A5_0001, dout_rdy=1.
   → ack_user[0] high the same cycle. Next cycle dout = {1, 5'd3, 4'd2, 7'd0, 32'hA5A50001}. Back-to-back packets carry addr 1, 2, ….
2. Fairness: all 3 routes valid, vld_user=111 for 6 cycles, dout_rdy=1.
   → grant order 0, 1, 2, 0, 1, 2. Each stream's addr ends at 2.
3. Backpressure: dout valid with dout_rdy=0 for 4 cycles.
   → dout stable, ack_user=0, ptr unchanged. On dout_rdy=1, the next grant continues the RR order.
4. Credits: stream 1 alone sends 128 packets.
   → 129th is not acked while streams 0 and 2 are still served. A single fs_vld with fs_idx=1 restores credit 64 and stream 1 resumes. Its next addr wraps to 0.
5. Overflow: fs_vld to stream 2 while its credit is 128.
   → credit stays 128 and credit_err=1 until reset.
6. Route write plus reset: rewrite stream 0's route in the same cycle it is granted.
   → that packet carries the old leaf/port and the next carries the new one. Assert reset mid-stream → dout=0 and all counters reinitialised next edge.

Source files
------------

// File: rtl/leaf_out_arbiter.sv
// Output-side scheduler for a leaf shell: round-robin arbitration of user output
// streams onto the single BFT packet channel, gated by per-stream credits.
module leaf_out_arbiter #(
   parameter int PACKET_BITS           = 49,
   parameter int PAYLOAD_BITS          = 32,
   parameter int NUM_LEAF_BITS         = 5,
   parameter int NUM_PORT_BITS         = 4,
   parameter int NUM_ADDR_BITS         = 7,
   parameter int NUM_OUT_PORTS         = 3,
   parameter int FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user,
   input  logic [NUM_OUT_PORTS-1:0]                vld_user,
   output logic [NUM_OUT_PORTS-1:0]                ack_user,
   input  logic                                    cfg_we,
   input  logic [2:0]                              cfg_idx,
   input  logic [NUM_LEAF_BITS-1:0]                cfg_leaf,
   input  logic [NUM_PORT_BITS-1:0]                cfg_port,
   input  logic                                    fs_vld,
   input  logic [2:0]                              fs_idx,
   output logic [PACKET_BITS-1:0]                  dout,
   input  logic                                    dout_rdy,
   output logic                                    credit_err
);

   localparam int PTR_W  = $clog2(NUM_OUT_PORTS);
   localparam int CRED_W = NUM_ADDR_BITS + 1;
   localparam int CRED_MAX = 1 << NUM_ADDR_BITS;
   localparam logic [CRED_W-1:0] CRED_INIT = {1'b1, {NUM_ADDR_BITS{1'b0}}};

   logic                     route_valid [NUM_OUT_PORTS];
   logic [NUM_LEAF_BITS-1:0] route_leaf  [NUM_OUT_PORTS];
   logic [NUM_PORT_BITS-1:0] route_port  [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] addr_cnt    [NUM_OUT_PORTS];
   logic [CRED_W-1:0]        credit      [NUM_OUT_PORTS];
   logic [CRED_W-1:0]        credit_nxt  [NUM_OUT_PORTS];
   logic [NUM_OUT_PORTS-1:0] credit_ovf;
   logic [NUM_OUT_PORTS-1:0] eligible;
   logic [PTR_W-1:0]         ptr;
   logic [PTR_W-1:0]         grant_idx;
   logic                     grant_vld;
   logic                     slot_free;
   logic [PAYLOAD_BITS-1:0]  grant_payload;
   logic [PACKET_BITS-1:0]   next_pkt;

   // A held packet blocks the slot until the BFT side takes it.
   assign slot_free = !dout[PACKET_BITS-1] || dout_rdy;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         eligible[i] = vld_user[i] && route_valid[i] && (credit[i] != '0);
      end
   end

   // Search starts just after the last granted stream, so the winner rotates.
   always_comb begin
      int cand;
      cand      = 0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
         cand = (int'(ptr) + k) % NUM_OUT_PORTS;
         if (!grant_vld && slot_free && eligible[cand]) begin
            grant_vld = 1'b1;
            grant_idx = PTR_W'(cand);
         end
      end
   end

   always_comb begin
      ack_user = '0;
      if (grant_vld) begin
         ack_user[grant_idx] = 1'b1;
      end
   end

   assign grant_payload = din_user[int'(grant_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
   assign next_pkt = {1'b1, route_leaf[grant_idx], route_port[grant_idx],
                      addr_cnt[grant_idx], grant_payload};

   // Grant and freespace return may hit the same stream; overflow saturates.
   always_comb begin
      int sum;
      sum        = 0;
      credit_ovf = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         sum = int'(credit[i]);
         if (grant_vld && int'(grant_idx) == i) begin
            sum = sum - 1;
         end
         if (fs_vld && int'(fs_idx) == i) begin
            sum = sum + FREESPACE_UPDATE_SIZE;
         end
         if (sum > CRED_MAX) begin
            credit_nxt[i] = CRED_INIT;
            credit_ovf[i] = 1'b1;
         end else begin
            credit_nxt[i] = CRED_W'(sum);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout       <= '0;
         ptr        <= PTR_W'(NUM_OUT_PORTS - 1);
         credit_err <= 1'b0;
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            route_valid[i] <= 1'b0;
            route_leaf[i]  <= '0;
            route_port[i]  <= '0;
            addr_cnt[i]    <= '0;
            credit[i]      <= CRED_INIT;
         end
      end else begin
         if (slot_free) begin
            dout <= grant_vld ? next_pkt : '0;
         end
         if (grant_vld) begin
            ptr <= grant_idx;
         end
         if (|credit_ovf) begin
            credit_err <= 1'b1;
         end
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit[i] <= credit_nxt[i];
            if (grant_vld && int'(grant_idx) == i) begin
               addr_cnt[i] <= addr_cnt[i] + 1'b1;
            end
            if (cfg_we && int'(cfg_idx) == i) begin
               route_valid[i] <= 1'b1;
               route_leaf[i]  <= cfg_leaf;
               route_port[i]  <= cfg_port;
            end
         end
      end
   end

endmodule
